bin_to_bcd_serial: RTL
======================

Name: bin_to_bcd_serial

Overview:
- Sequential binary-to-decimal converter: the reverse of the calculator's decimal-to-binary input path.
- Takes a signed 8-bit result from the register bank/ALU and produces sign + hundreds/tens/units BCD digits for the 7-segment display drivers.
- Uses iterative double-dabble (shift-and-add-3), one magnitude bit per clock, with valid/ready handshakes on both sides.

Parameters:
- DATA_W, 8: total input width including sign bit; legal range 4..10, so 3 BCD digits always suffice.

Ports:
- clk  input  1  single system clock, rising edge.
- rst_n  input  1  reset, asynchronous assert, active-low.
- in_valid  input  1  valor is valid.
- in_ready  output  1  block can accept a value; high only in IDLE.
- valor  input  DATA_W  sign-magnitude input: MSB is sign, lower DATA_W-1 bits are magnitude.
- out_valid  output  1  conversion result is valid; held until accepted.
- out_ready  input  1  consumer accepts the result.
- sinal  output  1  result sign, 1 = negative.
- centena  output  4  hundreds BCD digit.
- dezena  output  4  tens BCD digit.
- unidade  output  4  units BCD digit.

Behaviour:
- Reset: async on rst_n=0; state IDLE. in_ready=1 after reset; out_valid=0; sinal=0; all digits=0; internal shift register cleared. Any in-flight conversion is discarded.
- FSM states: IDLE, SHIFT, DONE.
- IDLE:
  - in_ready=1.
  - in_valid=1 at an edge: latch magnitude into shift register, latch sign, clear BCD accumulator, load iteration counter N, go to SHIFT.
  - N = DATA_W-1 (magnitude width).
- SHIFT:
  - Each cycle, every BCD digit >=5 gets +3, then {bcd, mag} shifts left by 1 and the counter decrements.
  - On the last iteration, go to DONE and register the final digits into the outputs.
- Latency: acceptance at edge k -> out_valid=1 after edge k+N (default N=7, i.e. 7 cycles).
- DONE:
  - out_valid=1 and outputs stable.
  - out_ready=1 at an edge -> IDLE; out_valid drops after that edge.
  - out_ready=0 -> hold indefinitely (backpressure).
- in_ready=0 in SHIFT and DONE; in_valid is ignored there, and no value is queued.
- DONE with out_ready=1 and in_valid=1 in the same cycle: the result is consumed; the new value is accepted at the next IDLE cycle, giving 1 bubble cycle.
- Output registers keep the last result after IDLE is entered. They update only on entry to DONE.
- Negative zero: valor=1000_0000 yields sinal=0, digits 0,0,0.
- Maximum default magnitude is 127 -> centena=1, dezena=2, unidade=7.
- No overflow is possible within the legal DATA_W range.
- X on valor while in_valid=0 must not propagate.

Optional Feature:
- Macro: BIN_TO_BCD_TWOS_COMP_EN.
- Defined: valor is interpreted as two's complement. On acceptance:
  - sinal = MSB.
  - magnitude = negated value when MSB=1, computed with DATA_W bits.
  - N = DATA_W.
  - Latency becomes DATA_W cycles.
  - Most negative value handled: 1000_0000 -> sinal=1, digits 1,2,8.
  - Zero always yields sinal=0.
- Undefined: sign-magnitude behaviour as above, N = DATA_W-1.

Decomposition:
- Package bin_to_bcd_pkg:
  - State enum {IDLE, SHIFT, DONE}.
  - BCD_DIGIT_W=4, NUM_DIGITS=3, ADJ_THRESHOLD=5, ADJ_VALUE=3.
  - Function for iteration count from DATA_W and the feature macro.
- Sub-module bcd_digit_adjust: purely combinational, 4-bit in/out, adds 3 when input >=5. Instantiated NUM_DIGITS times in the shift datapath.

Test Plan:
- Reset mid-SHIFT: assert rst_n=0 during cycle 3 of a conversion -> out_valid=0, in_ready=1, digits 0 immediately (async); no stale result appears after release.
- Default N=7 sign-magnitude cases, checking exact 7-cycle latency:
  - 0_0000000 -> +,0,0,0.
  - 0_1111111 -> +,1,2,7.
  - 1_0101010 -> -,0,4,2.
  - 1_0000000 -> +,0,0,0.
- Backpressure: hold out_ready=0 for 20 cycles -> out_valid stays 1, digits stable, in_ready=0, and in_valid pulses are ignored. Then out_ready=1 -> IDLE next cycle.
- Back-to-back: in_valid held 1 with values 99 then 100, out_ready tied 1 -> results 0,9,9 then 1,0,0, each 7 cycles after its acceptance, with a 1-cycle IDLE gap between.
- Exhaustive sweep: all 2^DATA_W inputs compared against a reference model (x/100, x/10%10, x%10).
- With BIN_TO_BCD_TWOS_COMP_EN:
  - 8'h80 -> -,1,2,8.
  - 8'hFF -> -,0,0,1.
  - 8'h7F -> +,1,2,7.
  - Latency is 8 cycles.

Source files
------------

// File: rtl/bin_to_bcd_pkg.sv
// Shared types, constants and iteration-count helper for the serial binary-to-BCD converter.
// Honours BIN_TO_BCD_TWOS_COMP_EN (two's-complement input interpretation).
package bin_to_bcd_pkg;

   typedef enum logic [1:0] {
      IDLE,
      SHIFT,
      DONE
   } state_e;

   localparam int unsigned BCD_DIGIT_W   = 4;
   localparam int unsigned NUM_DIGITS    = 3;
   localparam int unsigned ADJ_THRESHOLD = 5;
   localparam int unsigned ADJ_VALUE     = 3;

   // Two's complement needs the full width to hold the magnitude of the most negative value.
   function automatic int unsigned iter_count(input int unsigned data_w);
`ifdef BIN_TO_BCD_TWOS_COMP_EN
      return data_w;
`else
      return data_w - 1;
`endif
   endfunction

endpackage

// File: rtl/bin_to_bcd_serial_adjust.sv
// Double-dabble digit correction: adds 3 to a BCD digit that is 5 or more before the shift.
module bcd_digit_adjust
   import bin_to_bcd_pkg::*;
(
   input  logic [BCD_DIGIT_W-1:0] d_i,
   output logic [BCD_DIGIT_W-1:0] d_o
);

   always_comb begin
      d_o = d_i;
      if (d_i >= BCD_DIGIT_W'(ADJ_THRESHOLD)) begin
         d_o = d_i + BCD_DIGIT_W'(ADJ_VALUE);
      end
   end

endmodule

// File: rtl/bin_to_bcd_serial.sv
// Serial signed binary to sign + 3-digit BCD converter, one magnitude bit per clock.
// Define BIN_TO_BCD_TWOS_COMP_EN to treat valor as two's complement instead of sign-magnitude.
module bin_to_bcd_serial
   import bin_to_bcd_pkg::*;
#(
   parameter int unsigned DATA_W = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] valor,
   output logic              out_valid,
   input  logic              out_ready,
   output logic              sinal,
   output logic [3:0]        centena,
   output logic [3:0]        dezena,
   output logic [3:0]        unidade
);

   localparam int unsigned N     = iter_count(DATA_W);
   localparam int unsigned MAG_W = N;
   localparam int unsigned BCD_W = BCD_DIGIT_W * NUM_DIGITS;
   localparam int unsigned CNT_W = $clog2(N + 1);

   state_e           state_q, state_d;
   logic [MAG_W-1:0] mag_q, mag_d, mag_in;
   logic [BCD_W-1:0] bcd_q, bcd_d, bcd_adj;
   logic [BCD_W-1:0] res_q, res_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             sign_q, sign_d, sign_in;
   logic             sinal_q, sinal_d;

`ifdef BIN_TO_BCD_TWOS_COMP_EN
   always_comb begin
      sign_in = valor[DATA_W-1];
      mag_in  = valor[DATA_W-1] ? MAG_W'(-valor) : MAG_W'(valor);
   end
`else
   // Negative zero is reported as positive.
   always_comb begin
      sign_in = valor[DATA_W-1] & (|valor[DATA_W-2:0]);
      mag_in  = valor[DATA_W-2:0];
   end
`endif

   for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_adj
      bcd_digit_adjust u_adj (
         .d_i (bcd_q[g*BCD_DIGIT_W +: BCD_DIGIT_W]),
         .d_o (bcd_adj[g*BCD_DIGIT_W +: BCD_DIGIT_W])
      );
   end

   always_comb begin
      state_d = state_q;
      mag_d   = mag_q;
      bcd_d   = bcd_q;
      cnt_d   = cnt_q;
      sign_d  = sign_q;
      res_d   = res_q;
      sinal_d = sinal_q;
      case (state_q)
         IDLE: begin
            if (in_valid) begin
               mag_d   = mag_in;
               sign_d  = sign_in;
               bcd_d   = '0;
               cnt_d   = CNT_W'(N);
               state_d = SHIFT;
            end
         end
         SHIFT: begin
            bcd_d = {bcd_adj[BCD_W-2:0], mag_q[MAG_W-1]};
            mag_d = {mag_q[MAG_W-2:0], 1'b0};
            cnt_d = cnt_q - 1'b1;
            if (cnt_q == CNT_W'(1)) begin
               res_d   = {bcd_adj[BCD_W-2:0], mag_q[MAG_W-1]};
               sinal_d = sign_q;
               state_d = DONE;
            end
         end
         DONE: begin
            if (out_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         mag_q   <= '0;
         bcd_q   <= '0;
         cnt_q   <= '0;
         sign_q  <= 1'b0;
         res_q   <= '0;
         sinal_q <= 1'b0;
      end else begin
         state_q <= state_d;
         mag_q   <= mag_d;
         bcd_q   <= bcd_d;
         cnt_q   <= cnt_d;
         sign_q  <= sign_d;
         res_q   <= res_d;
         sinal_q <= sinal_d;
      end
   end

   assign in_ready  = (state_q == IDLE);
   assign out_valid = (state_q == DONE);
   assign sinal     = sinal_q;
   assign centena   = res_q[2*BCD_DIGIT_W +: BCD_DIGIT_W];
   assign dezena    = res_q[1*BCD_DIGIT_W +: BCD_DIGIT_W];
   assign unidade   = res_q[0 +: BCD_DIGIT_W];

endmodule
